// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file: read ports, writeback ports,
// destination allocation and the busy scoreboard view.
interface reg_file_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
);
  logic [NUM_RD*ADDR_WIDTH-1:0] iRdAddr;
  logic [NUM_RD*DATA_WIDTH-1:0] oRdData;
  logic [NUM_RD-1:0]            oRdBusy;
  logic [NUM_WR-1:0]            iWrEn;
  logic [NUM_WR*ADDR_WIDTH-1:0] iWrAddr;
  logic [NUM_WR*DATA_WIDTH-1:0] iWrData;
  logic                         iAllocEn;
  logic [ADDR_WIDTH-1:0]        iAllocAddr;
  logic [(2**ADDR_WIDTH)-1:0]   oBusyVec;

  modport master (
    output iRdAddr, iWrEn, iWrAddr, iWrData, iAllocEn, iAllocAddr,
    input  oRdData, oRdBusy, oBusyVec
  );

  modport slave (
    input  iRdAddr, iWrEn, iWrAddr, iWrData, iAllocEn, iAllocAddr,
    output oRdData, oRdBusy, oBusyVec
  );
endinterface

// File: rtl/reg_file_mp.sv
// Flop-based multi-port integer register file with hardwired-zero r0, optional
// write-to-read bypass and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]  r_busy;
  logic [NUM_WORDS-1:0]  w_wr_hit;
  logic [NUM_WORDS-1:0]  w_busy_nxt;

  always_comb begin
    w_wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.iWrEn[w]) begin
        w_wr_hit[bus.iWrAddr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  // A new allocation supersedes the producer whose writeback lands this cycle.
  always_comb begin
    w_busy_nxt = '0;
    for (int r = 1; r < NUM_WORDS; r++) begin
      if (bus.iAllocEn && (bus.iAllocAddr == ADDR_WIDTH'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (w_wr_hit[r]) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
  end

  // Ports are scanned in ascending order so the highest-index writer's NBA lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_WORDS; r++) begin
        r_mem[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.iWrEn[w] && (bus.iWrAddr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
          r_mem[bus.iWrAddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.iWrData[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.oBusyVec = r_busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_busy;
    logic                  w_byp;

    assign w_addr = bus.iRdAddr[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_byp  = 1'b0;
      w_data = r_mem[w_addr];
      w_busy = r_busy[w_addr];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.iWrEn[w] && (bus.iWrAddr[w*ADDR_WIDTH +: ADDR_WIDTH] == w_addr)) begin
            w_byp  = 1'b1;
            w_data = bus.iWrData[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (w_byp) begin
          w_busy = bus.iAllocEn && (bus.iAllocAddr == w_addr);
        end
      end
      if (w_addr == '0) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign bus.oRdData[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign bus.oRdBusy[p] = w_busy;
  end
endmodule
